// File: rtl/pc_seq_unit.sv
// Program-counter sequencer for the fetch stage: per-program start addresses,
// absolute/relative branches, call/return through a return-address stack, stall and halt.
module pc_seq_unit #(
  parameter int PC_WIDTH    = 12,
  parameter int OFF_WIDTH   = 8,
  parameter int NUM_PROGS   = 4,
  parameter int PROG_STRIDE = 256,
  parameter int RAS_DEPTH   = 4,
  localparam int PSEL_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  localparam int CNT_W      = $clog2(RAS_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PSEL_W-1:0]    prog_sel,
  input  logic                 stall,
  input  logic                 halt_en,
  input  logic                 branch_en,
  input  logic                 call_en,
  input  logic                 ret_en,
  input  logic                 branch_rel,
  input  logic [PC_WIDTH-1:0]  target,
  input  logic [OFF_WIDTH-1:0] offset,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 running,
  output logic                 done,
  output logic [CNT_W-1:0]     ras_cnt,
  output logic                 ras_err,
  output logic [1:0]           state_dbg
);

  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [PC_WIDTH-1:0]  pc_n;
  logic [CNT_W-1:0]     cnt_n;
  logic                 err_n;
  logic                 push;
  logic [PC_WIDTH-1:0]  ras_mem [2**IDX_W];

  logic [PSEL_W-1:0]    sel_eff;
  logic [31:0]          base_full;
  logic [PC_WIDTH-1:0]  base;
  logic [PC_WIDTH-1:0]  off_ext;
  logic [PC_WIDTH-1:0]  dest;
  logic [PC_WIDTH-1:0]  pc_inc;
  logic [CNT_W-1:0]     cnt_m1;
  logic [IDX_W-1:0]     push_idx;
  logic [IDX_W-1:0]     pop_idx;
  logic                 ras_full;

  // Out-of-range program numbers fall back to program 0.
  assign sel_eff   = (32'(prog_sel) < NUM_PROGS) ? prog_sel : '0;
  assign base_full = 32'(sel_eff) * 32'(PROG_STRIDE);
  assign base      = base_full[PC_WIDTH-1:0];

  assign off_ext   = PC_WIDTH'($signed(offset));
  assign pc_inc    = pc + PC_WIDTH'(1);
  assign dest      = branch_rel ? (pc + off_ext) : target;

  assign cnt_m1    = ras_cnt - CNT_W'(1);
  assign push_idx  = ras_cnt[IDX_W-1:0];
  assign pop_idx   = cnt_m1[IDX_W-1:0];
  assign ras_full  = (32'(ras_cnt) >= RAS_DEPTH);

  assign state_dbg = state;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = ras_cnt;
    err_n   = ras_err;
    push    = 1'b0;
    if (start) begin
      // start wins in every state, even over stall, and empties the stack.
      state_n = S_RUN;
      pc_n    = base;
      cnt_n   = '0;
      err_n   = 1'b0;
    end else if (state == S_RUN && !stall) begin
      if (halt_en) begin
        state_n = S_HALT;
      end else if (ret_en) begin
        // A return on an empty stack falls through to the next instruction.
        if (ras_cnt != '0) begin
          pc_n  = ras_mem[pop_idx];
          cnt_n = cnt_m1;
        end else begin
          pc_n  = pc_inc;
          err_n = 1'b1;
        end
      end else if (call_en) begin
        pc_n = dest;
        if (ras_full) begin
          err_n = 1'b1;
        end else begin
          push  = 1'b1;
          cnt_n = ras_cnt + CNT_W'(1);
        end
      end else if (branch_en) begin
        pc_n = dest;
      end else begin
        pc_n = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      ras_cnt <= '0;
      ras_err <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      ras_cnt <= cnt_n;
      ras_err <= err_n;
      running <= (state_n == S_RUN);
      done    <= (state_n == S_HALT);
    end
  end

  // Stack storage needs no reset: ras_cnt alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      ras_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed scenarios plus randomized control
// streams compared against a queue-based model of the sequencer.
module tb_pc_seq_unit;

  localparam int NPROG = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  prog_sel;
  logic        stall, halt_en, branch_en, call_en, ret_en, branch_rel;
  logic [11:0] target;
  logic [7:0]  offset;
  logic [11:0] pc;
  logic        running, done;
  logic [2:0]  ras_cnt;
  logic        ras_err;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int fails = 0;

  pc_seq_unit #(
    .PC_WIDTH(12), .OFF_WIDTH(8), .NUM_PROGS(NPROG), .PROG_STRIDE(256), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .stall(stall),
    .halt_en(halt_en), .branch_en(branch_en), .call_en(call_en), .ret_en(ret_en),
    .branch_rel(branch_rel), .target(target), .offset(offset), .pc(pc),
    .running(running), .done(done), .ras_cnt(ras_cnt), .ras_err(ras_err),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0=idle, 1=run, 2=halt; the stack is a plain queue.
  int          m_mode;
  logic [11:0] m_pc;
  logic [11:0] m_stack[$];
  bit          m_err;

  wire [17:0] act_vec = {pc, running, done, ras_cnt, ras_err};

  function automatic logic [17:0] exp_vec();
    return {m_pc, m_mode == 1, m_mode == 2, 3'(m_stack.size()), m_err};
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_pc   = 12'd0;
    m_stack.delete();
    m_err  = 1'b0;
  endfunction

  function automatic logic [11:0] m_dest();
    int s;
    s = int'($signed(offset));
    if (branch_rel) return 12'((int'(m_pc) + s) & 32'hFFF);
    return target;
  endfunction

  function automatic void model_step();
    logic [11:0] d;
    if (start) begin
      m_mode = 1;
      m_pc   = 12'(((int'(prog_sel) < NPROG) ? int'(prog_sel) : 0) * 256);
      m_stack.delete();
      m_err  = 1'b0;
    end else if (m_mode == 1 && !stall) begin
      if (halt_en) m_mode = 2;
      else if (ret_en) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_pc = m_pc + 12'd1; m_err = 1'b1; end
      end else if (call_en) begin
        d = m_dest();
        if (m_stack.size() < 4) m_stack.push_back(m_pc + 12'd1);
        else m_err = 1'b1;
        m_pc = d;
      end else if (branch_en) m_pc = m_dest();
      else m_pc = m_pc + 12'd1;
    end
  endfunction

  // Driver tasks: inputs change only at the falling edge.
  task automatic clear_inputs();
    start = 0; prog_sel = 0; stall = 0; halt_en = 0; branch_en = 0;
    call_en = 0; ret_en = 0; branch_rel = 0; target = 0; offset = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_start(input logic [1:0] sel);
    start = 1; prog_sel = sel;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if ({pc, running, done} !== {12'd0, 1'b0, 1'b0}) begin
        fails++; $display("FAIL reset_idle cyc%0d pc=%h run=%b done=%b want pc=000 run=0 done=0", i, pc, running, done);
      end
    end
    // controls other than start are ignored while idle
    branch_en = 1; call_en = 1; target = 12'h123; halt_en = 1;
    step();
    tests_run++;
    if (act_vec !== exp_vec() || pc !== 12'd0) begin
      fails++; $display("FAIL idle_ignore got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_branch();
    do_start(2'd2);
    tests_run++;
    if (pc !== 12'd512 || running !== 1'b1) begin
      fails++; $display("FAIL start_base pc=%0d run=%b want 512/1", pc, running);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      tests_run++;
      if (pc !== 12'(512 + i)) begin
        fails++; $display("FAIL seq_inc pc=%0d want %0d", pc, 512 + i);
      end
    end
    branch_rel = 1; offset = 8'hFD; branch_en = 1;
    step();
    tests_run++;
    if (pc !== 12'd512) begin
      fails++; $display("FAIL rel_branch pc=%0d want 512", pc);
    end
    branch_en = 1; target = 12'hFFF;
    step();
    step();
    tests_run++;
    if (pc !== 12'h000 || act_vec !== exp_vec()) begin
      fails++; $display("FAIL pc_wrap pc=%h want 000", pc);
    end
    branch_rel = 1; offset = 8'h05; branch_en = 1;
    step();
    tests_run++;
    if (pc !== 12'h005) begin
      fails++; $display("FAIL rel_fwd pc=%h want 005", pc);
    end
    do_start(2'd3);
    tests_run++;
    if (pc !== 12'd0 || running !== 1'b1) begin
      fails++; $display("FAIL bad_prog pc=%h want 000", pc);
    end
  endtask

  task automatic test_call_ret();
    do_start(2'd0);
    branch_en = 1; target = 12'h010;
    step();
    call_en = 1; target = 12'h200;
    step();
    tests_run++;
    if (pc !== 12'h200 || ras_cnt !== 3'd1) begin
      fails++; $display("FAIL call1 pc=%h cnt=%0d want 200/1", pc, ras_cnt);
    end
    repeat (5) step();
    call_en = 1; target = 12'h300;
    step();
    tests_run++;
    if (pc !== 12'h300 || ras_cnt !== 3'd2) begin
      fails++; $display("FAIL call2 pc=%h cnt=%0d want 300/2", pc, ras_cnt);
    end
    ret_en = 1; call_en = 1; target = 12'h7AA;
    step();
    tests_run++;
    if (pc !== 12'h206 || ras_cnt !== 3'd1) begin
      fails++; $display("FAIL ret1 pc=%h cnt=%0d want 206/1", pc, ras_cnt);
    end
    ret_en = 1;
    step();
    tests_run++;
    if ({pc, ras_cnt, ras_err} !== {12'h011, 3'd0, 1'b0}) begin
      fails++; $display("FAIL ret2 pc=%h cnt=%0d err=%b want 011/0/0", pc, ras_cnt, ras_err);
    end
  endtask

  task automatic test_ras_overflow();
    logic [11:0] t[5];
    do_start(2'd1);
    for (int i = 0; i < 5; i++) begin
      t[i] = 12'(12'h400 + i * 12'h040 + $urandom_range(0, 15));
      call_en = 1; target = t[i];
      step();
    end
    tests_run++;
    if ({pc, ras_cnt, ras_err} !== {t[4], 3'd4, 1'b1}) begin
      fails++; $display("FAIL ras_full pc=%h cnt=%0d err=%b want %h/4/1", pc, ras_cnt, ras_err, t[4]);
    end
    for (int i = 0; i < 5; i++) begin
      logic [11:0] want;
      want = (i < 3) ? t[2 - i] + 12'd1 : (i == 3 ? 12'd257 : 12'd258);
      ret_en = 1;
      step();
      tests_run++;
      if (pc !== want || act_vec !== exp_vec()) begin
        fails++; $display("FAIL ras_pop%0d pc=%h want %h", i, pc, want);
      end
    end
    do_start(2'd0);
    tests_run++;
    if (ras_err !== 1'b0 || ras_cnt !== 3'd0) begin
      fails++; $display("FAIL start_clr err=%b cnt=%0d want 0/0", ras_err, ras_cnt);
    end
  endtask

  task automatic test_stall_halt();
    logic [11:0] held;
    do_start(2'd0);
    step();
    held = pc;
    for (int i = 0; i < 3; i++) begin
      stall = 1; branch_en = 1; target = 12'($urandom_range(0, 4095));
      step();
      tests_run++;
      if (pc !== held) begin
        fails++; $display("FAIL stall_hold pc=%h want %h", pc, held);
      end
    end
    stall = 1; start = 1; prog_sel = 2;
    step();
    tests_run++;
    if (pc !== 12'd512) begin
      fails++; $display("FAIL stall_start pc=%0d want 512", pc);
    end
    halt_en = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      branch_en = 1; ret_en = (i == 1); target = 12'h0AB;
      step();
      tests_run++;
      if ({pc, done, running} !== {12'd512, 1'b1, 1'b0}) begin
        fails++; $display("FAIL halt_hold pc=%0d done=%b run=%b want 512/1/0", pc, done, running);
      end
    end
    do_start(2'd1);
    tests_run++;
    if ({pc, running, done} !== {12'd256, 1'b1, 1'b0}) begin
      fails++; $display("FAIL halt_restart pc=%0d run=%b done=%b want 256/1/0", pc, running, done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start      = ($urandom_range(0, 39) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0);
      prog_sel   = 2'($urandom_range(0, 3));
      stall      = ($urandom_range(0, 5) == 0);
      halt_en    = ($urandom_range(0, 49) == 0);
      ret_en     = ($urandom_range(0, 3) == 0);
      call_en    = ($urandom_range(0, 3) == 0);
      branch_en  = ($urandom_range(0, 3) == 0);
      branch_rel = 1'($urandom_range(0, 1));
      target     = 12'($urandom_range(0, 4095));
      offset     = 8'($urandom_range(0, 255));
      step();
      tests_run++;
      if (act_vec !== exp_vec()) begin
        fails++; $display("FAIL rand cyc%0d {pc,run,done,cnt,err} got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    do_start(2'd0);
    call_en = 1; target = 12'h100;
    step();
    call_en = 1; target = 12'h180;
    step();
    tests_run++;
    if (ras_cnt !== 3'd2 || running !== 1'b1) begin
      fails++; $display("FAIL pre_reset cnt=%0d run=%b want 2/1", ras_cnt, running);
    end
    #2 reset = 0;
    #1;
    tests_run++;
    if ({pc, ras_cnt, running, done, ras_err} !== {12'd0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL async_reset pc=%h cnt=%0d run=%b want 000/0/0", pc, ras_cnt, running);
    end
    model_reset();
    @(negedge clk);
    reset = 1;
    do_start(2'd1);
    ret_en = 1;
    step();
    tests_run++;
    if ({pc, ras_err} !== {12'd257, 1'b1} || act_vec !== exp_vec()) begin
      fails++; $display("FAIL post_reset_empty pc=%0d err=%b want 257/1", pc, ras_err);
    end
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    model_reset();
    test_reset();
    test_branch();
    test_call_ret();
    test_ras_overflow();
    test_stall_halt();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
